// File: rtl/spi_slave_regif_if.sv
// SPI pin group plus the register-file side bus for spi_slave_regif.
// The slave modport is the engine's view; the master modport is the pad/register-file view.
interface spi_slave_regif_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rd_data;

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, reg_rd_data,
    output spi_miso, spi_miso_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, reg_rd_data,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );
endinterface

// File: rtl/spi_slave_regif.sv
// Oversampled SPI slave bridging an MCU SPI port to an internal register file.
// Frame: {rw, addr} command word, then a burst of data words, all MSB first.
module spi_slave_regif #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CPOL     = 0,
  parameter int unsigned CPHA     = 0,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  spi_slave_regif_if.slave bus,
  output logic             busy,
  output logic             frame_err
);
  localparam int unsigned SW   = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int unsigned RxW  = SW - 1;
  localparam int unsigned CntW = $clog2(SW);
  localparam logic [CntW-1:0] CmdLast  = CntW'(ADDR_W);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdData} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sck_q, sck_d;
  logic [2:0]        cs_q, cs_d;
  logic [1:0]        mosi_q, mosi_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RxW-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              load_q, load_d;
  logic              first_q, first_d;
  logic              frame_err_q, frame_err_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, mosi_s, miso_oe;
  logic [ADDR_W:0]   cmd_word;
  logic [DATA_W-1:0] data_word;

  // Edges come from taps [2:1]; mosi_q[1] lines up with sck_q[1].
  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];
  assign mosi_s      = mosi_q[1];
  assign cmd_word    = {rx_q[ADDR_W-1:0], mosi_s};
  assign data_word   = {rx_q[DATA_W-2:0], mosi_s};

  always_comb begin
    sck_d       = {sck_q[1:0], bus.spi_clk};
    cs_d        = {cs_q[1:0], bus.spi_cs_n};
    mosi_d      = {mosi_q[0], bus.spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    load_d      = rd_en_q;
    first_d     = first_q;
    frame_err_d = 1'b0;

    // Post-write increment lands the cycle after the strobe.
    if (wr_en_q && (AUTO_INC != 0)) addr_d = addr_q + ADDR_W'(1);
    if (load_q) begin
      tx_d    = bus.reg_rd_data;
      first_d = 1'b1;
    end

    if (state_q == StIdle) begin
      if (cs_fall) begin
        state_d   = StCmd;
        bit_cnt_d = '0;
      end
    end else if (cs_rise) begin
      // CS release beats any coincident SCK edge.
      state_d     = StIdle;
      bit_cnt_d   = '0;
      frame_err_d = (bit_cnt_q != '0);
    end else if (sample_edge) begin
      rx_d      = {rx_q[RxW-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + CntW'(1);
      case (state_q)
        StCmd: begin
          if (bit_cnt_q == CmdLast) begin
            bit_cnt_d = '0;
            addr_d    = cmd_word[ADDR_W-1:0];
            if (cmd_word[ADDR_W]) begin
              state_d = StRdData;
              rd_en_d = 1'b1;
            end else begin
              state_d = StWrData;
            end
          end
        end
        StWrData: begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            wr_data_d = data_word;
            wr_en_d   = 1'b1;
          end
        end
        StRdData: begin
          // Prefetch the next word so it is loaded before the next shift edge.
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            rd_en_d   = 1'b1;
            if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end else if (shift_edge && (state_q == StRdData)) begin
      if (first_q) first_d = 1'b0;
      else         tx_d    = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      sck_q       <= '0;
      cs_q        <= '0;
      mosi_q      <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      load_q      <= 1'b0;
      first_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      load_q      <= load_d;
      first_q     <= first_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_oe         = (state_q == StRdData) && ~cs_q[1];
  assign bus.spi_miso_oe = miso_oe;
  assign bus.spi_miso    = miso_oe & tx_q[DATA_W-1];
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign busy            = (state_q != StIdle);
  assign frame_err       = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench: four 7/8-bit slaves (one per SPI mode) and one 15/16-bit slave
// share SCK/MOSI; each has its own chip select.
module tb_spi_slave_regif;
  localparam int H = 8;  // SCK half period in sys_clk cycles

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic ph, mosi;
  logic [4:0] cs_n;
  always #5 sys_clk = ~sys_clk;

  logic [4:0]       wr_en_v, rd_en_v, miso_v, oe_v, busy_v, ferr_v;
  logic [4:0][15:0] addr_a, wdat_a;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    logic [7:0] rd_data;
    spi_slave_regif_if #(.ADDR_W(7), .DATA_W(8)) bus ();
    spi_slave_regif #(
      .ADDR_W(7), .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .AUTO_INC(1)
    ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus), .busy(busy_v[g]), .frame_err(ferr_v[g])
    );
    assign bus.spi_clk     = ph ^ (g >= 2);
    assign bus.spi_cs_n    = cs_n[g];
    assign bus.spi_mosi    = mosi;
    assign bus.reg_rd_data = rd_data;
    always @(posedge sys_clk) if (bus.reg_rd_en) rd_data <= {1'b0, bus.reg_addr} + 8'h40;
    assign wr_en_v[g] = bus.reg_wr_en;
    assign rd_en_v[g] = bus.reg_rd_en;
    assign miso_v[g]  = bus.spi_miso;
    assign oe_v[g]    = bus.spi_miso_oe;
    assign addr_a[g]  = {9'd0, bus.reg_addr};
    assign wdat_a[g]  = {8'd0, bus.reg_wr_data};
  end

  spi_slave_regif_if #(.ADDR_W(15), .DATA_W(16)) wbus ();
  spi_slave_regif #(
    .ADDR_W(15), .DATA_W(16), .CPOL(0), .CPHA(0), .AUTO_INC(0)
  ) u_wide (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(wbus), .busy(busy_v[4]), .frame_err(ferr_v[4])
  );
  assign wbus.spi_clk     = ph;
  assign wbus.spi_cs_n    = cs_n[4];
  assign wbus.spi_mosi    = mosi;
  assign wbus.reg_rd_data = 16'h0;
  assign wr_en_v[4] = wbus.reg_wr_en;
  assign rd_en_v[4] = wbus.reg_rd_en;
  assign miso_v[4]  = wbus.spi_miso;
  assign oe_v[4]    = wbus.spi_miso_oe;
  assign addr_a[4]  = {1'b0, wbus.reg_addr};
  assign wdat_a[4]  = wbus.reg_wr_data;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  int  ferr_cnt[5] = '{default: 0};

  always @(negedge sys_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (wr_en_v[i]) wr_q.push_back('{3'(i), addr_a[i], wdat_a[i]});
      if (rd_en_v[i]) rd_q.push_back('{3'(i), addr_a[i], 16'h0});
      if (ferr_v[i]) ferr_cnt[i]++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-agnostic master: MOSI is stable across both SCK edges of its bit; MISO is
  // captured at the edge where the master of that mode samples.
  task automatic xfer(input int m, input int nbits, input logic [15:0] wd,
                      output logic [15:0] rd, output int oe_hi);
    logic cpha;
    cpha  = (m % 2 == 1);
    rd    = '0;
    oe_hi = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      tick(H / 2);
      mosi = wd[i];
      tick(H / 2);
      if (!cpha) begin
        rd[i] = miso_v[m];
        if (oe_v[m]) oe_hi++;
      end
      ph = 1'b1;
      tick(H);
      if (cpha) begin
        rd[i] = miso_v[m];
        if (oe_v[m]) oe_hi++;
      end
      ph = 1'b0;
    end
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(input int m);
    tick(H);
    cs_n[m] = 1'b1;
    tick(2 * H);
  endtask

  logic [15:0] rd;
  int oe, n0, n1, f0;

  initial begin
    sys_rst = 1'b1;
    ph      = 1'b0;
    mosi    = 1'b0;
    cs_n    = '1;
    tick(5);
    sys_rst = 1'b0;
    tick(2);

    check("rst_busy", busy_v, 0);
    check("rst_oe", oe_v, 0);
    check("rst_miso", miso_v, 0);
    check("rst_strobes", {wr_en_v, rd_en_v, ferr_v}, 0);
    check("rst_addr0", addr_a[0], 0);

    // Mode 0 single write, busy drops on the third clock after CS release.
    n0 = wr_q.size();
    f0 = ferr_cnt[0];
    cs_low(0);
    xfer(0, 8, 16'h12, rd, oe);
    xfer(0, 8, 16'hA5, rd, oe);
    tick(H);
    cs_n[0] = 1'b1;
    tick(2);
    check("t1_busy_hold", busy_v[0], 1);
    tick(1);
    check("t1_busy_fall", busy_v[0], 0);
    tick(2 * H);
    check("t1_wr_cnt", wr_q.size() - n0, 1);
    check("t1_wr_addr", wr_q[n0].addr, 16'h12);
    check("t1_wr_data", wr_q[n0].data, 16'hA5);
    check("t1_addr_inc", addr_a[0], 16'h13);
    check("t1_ferr", ferr_cnt[0] - f0, 0);

    // Mode 3 read burst from address 5.
    n0 = rd_q.size();
    cs_low(3);
    xfer(3, 8, 16'h85, rd, oe);
    check("t2_oe_cmd", oe, 0);
    xfer(3, 8, 16'h0, rd, oe);
    check("t2_byte0", rd, 16'h45);
    check("t2_oe_data", oe, 8);
    xfer(3, 8, 16'h0, rd, oe);
    check("t2_byte1", rd, 16'h46);
    xfer(3, 8, 16'h0, rd, oe);
    check("t2_byte2", rd, 16'h47);
    cs_high(3);
    check("t2_oe_after", oe_v[3], 0);
    check("t2_rd_cnt", rd_q.size() - n0, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2_rd_addr%0d", k), {rd_q[n0 + k].idx, rd_q[n0 + k].addr},
            {3'd3, 16'(5 + k)});
    check("t2_ferr", ferr_cnt[3], 0);

    // Every mode: burst write at 0x7F wraps to 0x00.
    for (int m = 0; m < 4; m++) begin
      n0 = wr_q.size();
      cs_low(m);
      xfer(m, 8, 16'h7F, rd, oe);
      xfer(m, 8, 16'h01, rd, oe);
      xfer(m, 8, 16'h02, rd, oe);
      cs_high(m);
      check($sformatf("t3_m%0d_cnt", m), wr_q.size() - n0, 2);
      check($sformatf("t3_m%0d_w0", m), wr_q[n0], {3'(m), 16'h7F, 16'h01});
      check($sformatf("t3_m%0d_w1", m), wr_q[n0 + 1], {3'(m), 16'h00, 16'h02});
    end

    // Abort after 5 data bits, then a clean frame.
    n0 = wr_q.size();
    f0 = ferr_cnt[0];
    cs_low(0);
    xfer(0, 8, 16'h02, rd, oe);
    xfer(0, 5, 16'h1F, rd, oe);
    cs_high(0);
    check("t4_no_wr", wr_q.size() - n0, 0);
    check("t4_ferr", ferr_cnt[0] - f0, 1);
    cs_low(0);
    xfer(0, 8, 16'h02, rd, oe);
    xfer(0, 8, 16'h11, rd, oe);
    cs_high(0);
    check("t4_wr_cnt", wr_q.size() - n0, 1);
    check("t4_wr", wr_q[n0], {3'd0, 16'h02, 16'h11});
    check("t4_ferr_after", ferr_cnt[0] - f0, 1);

    // Wide slave, fixed address.
    n0 = wr_q.size();
    cs_low(4);
    xfer(4, 16, 16'h1234, rd, oe);
    xfer(4, 16, 16'hBEEF, rd, oe);
    xfer(4, 16, 16'hCAFE, rd, oe);
    cs_high(4);
    check("t5_wr_cnt", wr_q.size() - n0, 2);
    check("t5_w0", wr_q[n0], {3'd4, 16'h1234, 16'hBEEF});
    check("t5_w1", wr_q[n0 + 1], {3'd4, 16'h1234, 16'hCAFE});
    check("t5_addr_fixed", addr_a[4], 16'h1234);

    // Reset in the middle of a mode 0 read from 0x10 (data 0x50).
    n0 = rd_q.size();
    f0 = ferr_cnt[0];
    cs_low(0);
    xfer(0, 8, 16'h90, rd, oe);
    xfer(0, 3, 16'h0, rd, oe);
    check("t6_first_bits", rd, 16'h2);
    check("t6_rd", {rd_q[n0].idx, rd_q[n0].addr}, {3'd0, 16'h10});
    sys_rst = 1'b1;
    tick(1);
    check("t6_rst_busy", busy_v[0], 0);
    check("t6_rst_oe", oe_v[0], 0);
    check("t6_rst_miso", miso_v[0], 0);
    check("t6_rst_addr", addr_a[0], 0);
    check("t6_rst_wdat", wdat_a[0], 0);
    sys_rst = 1'b0;
    n0 = wr_q.size();
    n1 = rd_q.size();
    xfer(0, 8, 16'h90, rd, oe);
    xfer(0, 8, 16'h05, rd, oe);
    xfer(0, 8, 16'hAA, rd, oe);
    check("t6_still_idle", busy_v[0], 0);
    check("t6_no_strobes", (wr_q.size() - n0) + (rd_q.size() - n1), 0);
    cs_high(0);
    check("t6_no_ferr", ferr_cnt[0] - f0, 0);
    cs_low(0);
    xfer(0, 8, 16'h03, rd, oe);
    xfer(0, 8, 16'h77, rd, oe);
    cs_high(0);
    check("t6_recover_cnt", wr_q.size() - n0, 1);
    check("t6_recover_wr", wr_q[n0], {3'd0, 16'h03, 16'h77});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
